// File: rtl/mdu_e_pkg.sv
// Shared MDU op/state encodings and decode helpers.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU encodings.
package mdu_e_pkg;

  typedef enum logic [3:0] {
    MDU_OP_NONE  = 4'd0,
    MDU_OP_MULT  = 4'd1,
    MDU_OP_MULTU = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_MTHI  = 4'd5,
    MDU_OP_MTLO  = 4'd6,
    MDU_OP_MFHI  = 4'd7,
    MDU_OP_MFLO  = 4'd8,
    MDU_OP_MADD  = 4'd9,
    MDU_OP_MADDU = 4'd10,
    MDU_OP_MSUB  = 4'd11,
    MDU_OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    MDU_ST_IDLE = 1'b0,
    MDU_ST_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for a multi-cycle run.
  function automatic logic is_start_op(input logic [3:0] op);
    case (op)
      MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_OP_MADD, MDU_OP_MADDU, MDU_OP_MSUB, MDU_OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic is_mdu_op(input logic [3:0] op);
    return is_start_op(op) || (op == MDU_OP_MTHI) || (op == MDU_OP_MTLO) ||
           (op == MDU_OP_MFHI) || (op == MDU_OP_MFLO);
  endfunction

endpackage

// File: rtl/mdu_e_calc.sv
// Combinational MDU arithmetic: 64-bit {HI,LO} result plus divide-by-zero flag.
// MDU_MADD_EN adds the accumulate/subtract forms.
module mdu_calc
  import mdu_e_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] sa, sb, prod_s;
  logic        [63:0] ua, ub, prod_u;
  logic signed [31:0] sdiv_a, sdiv_b, squot, srem;
  logic        [31:0] udiv_b;

  always_comb begin
    sa     = {{32{a[31]}}, a};
    sb     = {{32{b[31]}}, b};
    ua     = {32'h0, a};
    ub     = {32'h0, b};
    prod_s = sa * sb;
    prod_u = ua * ub;
    // Divisor forced to 1 on zero so the datapath stays defined; the flag suppresses commit.
    udiv_b = (b == '0) ? 32'd1 : b;
    sdiv_a = a;
    sdiv_b = udiv_b;
    squot  = sdiv_a / sdiv_b;
    srem   = sdiv_a % sdiv_b;
  end

  always_comb begin
    result   = {hi, lo};
    div_zero = is_div_op(op) && (b == '0);
    case (op)
      MDU_OP_MULT:  result = prod_s;
      MDU_OP_MULTU: result = prod_u;
      MDU_OP_DIV:   result = {srem, squot};
      MDU_OP_DIVU:  result = {a % udiv_b, a / udiv_b};
`ifdef MDU_MADD_EN
      MDU_OP_MADD:  result = {hi, lo} + prod_s;
      MDU_OP_MADDU: result = {hi, lo} + prod_u;
      MDU_OP_MSUB:  result = {hi, lo} - prod_s;
      MDU_OP_MSUBU: result = {hi, lo} - prod_u;
`endif
      default:      result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: issue FSM, latency counter, HI/LO ownership.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (otherwise they decode as no-ops).
module mdu_e
  import mdu_e_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MDU_i_A,
  input  logic [31:0] MDU_i_B,
  input  logic [3:0]  MDU_i_op,
  input  logic        MDU_i_flush,
  output logic        MDU_o_busy,
  output logic        MDU_o_startOrBusy,
  output logic [31:0] MDU_o_HI,
  output logic [31:0] MDU_o_LO,
  output logic [31:0] MDU_o_rdata
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e      state, next_state;
  logic [CW-1:0]   cnt;
  logic [63:0]     temp;
  logic            temp_dz;
  logic [31:0]     hi, lo;
  logic [63:0]     calc_result;
  logic            calc_dz;
  logic            busy, start_op, issue, last;

  mdu_calc u_calc (
    .op       (MDU_i_op),
    .a        (MDU_i_A),
    .b        (MDU_i_B),
    .hi       (hi),
    .lo       (lo),
    .result   (calc_result),
    .div_zero (calc_dz)
  );

  assign busy     = (state == MDU_ST_BUSY);
  assign start_op = is_start_op(MDU_i_op) && !MDU_i_flush;
  assign issue    = start_op && (state == MDU_ST_IDLE);
  assign last     = (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MDU_ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      MDU_ST_IDLE: if (issue) next_state = MDU_ST_BUSY;
      MDU_ST_BUSY: if (last)  next_state = MDU_ST_IDLE;
      default:     next_state = MDU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      temp    <= '0;
      temp_dz <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (issue) begin
      temp    <= calc_result;
      temp_dz <= calc_dz;
      cnt     <= is_div_op(MDU_i_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (last && !temp_dz) {hi, lo} <= temp;
    end else if (!MDU_i_flush) begin
      if (MDU_i_op == MDU_OP_MTHI) hi <= MDU_i_A;
      if (MDU_i_op == MDU_OP_MTLO) lo <= MDU_i_A;
    end
  end

  always_comb begin
    MDU_o_rdata = '0;
    if (MDU_i_op == MDU_OP_MFHI) MDU_o_rdata = hi;
    if (MDU_i_op == MDU_OP_MFLO) MDU_o_rdata = lo;
  end

  assign MDU_o_busy        = busy;
  assign MDU_o_startOrBusy = busy || start_op;
  assign MDU_o_HI          = hi;
  assign MDU_o_LO          = lo;

`ifndef SYNTHESIS
  logic op_valid;
  assign op_valid = is_mdu_op(MDU_i_op);
  no_op_while_busy: assert property (@(posedge clk) disable iff (reset) busy |-> !op_valid);
`endif

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e against a plain-arithmetic HI/LO reference model.
// Build with MDU_MADD_EN defined to also exercise the accumulate ops.
module tb_mdu_e;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_s = '0, b_s = '0;
  logic [3:0]  op_s = '0;
  logic        flush_s = 1'b0;
  logic        busy, sob;
  logic [31:0] hi, lo, rdata;

  int tests = 0;
  int failed = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  mdu_e #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk               (clk),
    .reset             (rst),
    .MDU_i_A           (a_s),
    .MDU_i_B           (b_s),
    .MDU_i_op          (op_s),
    .MDU_i_flush       (flush_s),
    .MDU_o_busy        (busy),
    .MDU_o_startOrBusy (sob),
    .MDU_o_HI          (hi),
    .MDU_o_LO          (lo),
    .MDU_o_rdata       (rdata)
  );

  always #5 clk = ~clk;

  // Reference: updates m_hi/m_lo as the op's final effect, returns expected busy cycles.
  function automatic int ref_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint sp;
    longint unsigned ua, ub, up;
    logic [63:0] acc;
    sa = a; sb = b;
    sp = longint'(sa) * longint'(sb);
    ua = {32'h0, a}; ub = {32'h0, b};
    up = ua * ub;
    acc = {m_hi, m_lo};
    case (op)
      4'd1: begin {m_hi, m_lo} = sp; return MULT_N; end
      4'd2: begin {m_hi, m_lo} = up; return MULT_N; end
      4'd3: begin if (b != 0) begin m_lo = sa / sb; m_hi = sa % sb; end return DIV_N; end
      4'd4: begin if (b != 0) begin m_lo = a / b; m_hi = a % b; end return DIV_N; end
      4'd5: begin m_hi = a; return 0; end
      4'd6: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
      4'd9:  begin {m_hi, m_lo} = acc + sp; return MULT_N; end
      4'd10: begin {m_hi, m_lo} = acc + up; return MULT_N; end
      4'd11: begin {m_hi, m_lo} = acc - sp; return MULT_N; end
      4'd12: begin {m_hi, m_lo} = acc - up; return MULT_N; end
`endif
      default: return 0;
    endcase
  endfunction

  task automatic check_regs(input string name);
    tests++;
    if (hi !== m_hi || lo !== m_lo) begin
      failed++;
      $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi, lo, m_hi, m_lo);
    end
  endtask

  // Issue one op in a cycle, then count busy cycles (bounded) and check HI/LO afterwards.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int n, cnt;
    n = ref_exec(op, a, b);
    @(negedge clk);
    op_s = op; a_s = a; b_s = b; flush_s = 1'b0;
    #1;
    tests++;
    if (sob !== (n > 0)) begin
      failed++;
      $display("FAIL %s startOrBusy: got %b expected %b", name, sob, (n > 0));
    end
    @(negedge clk);
    op_s = 4'd0; a_s = $urandom; b_s = $urandom;
    cnt = 0;
    while (busy === 1'b1 && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
    tests++;
    if (cnt != n) begin
      failed++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cnt, n);
    end
    check_regs(name);
  endtask

  task automatic check_reads(input string name);
    @(negedge clk); op_s = 4'd7; #1;
    tests++;
    if (rdata !== m_hi) begin failed++; $display("FAIL %s mfhi: got %h expected %h", name, rdata, m_hi); end
    @(negedge clk); op_s = 4'd8; #1;
    tests++;
    if (rdata !== m_lo) begin failed++; $display("FAIL %s mflo: got %h expected %h", name, rdata, m_lo); end
    @(negedge clk); op_s = 4'd0; #1;
    tests++;
    if (rdata !== 32'h0) begin failed++; $display("FAIL %s rdata_none: got %h expected 0", name, rdata); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    tests++;
    if (busy !== 1'b0 || sob !== 1'b0) begin
      failed++;
      $display("FAIL reset busy: got %b/%b expected 0/0", busy, sob);
    end
    check_regs("reset");
  endtask

  task automatic test_mult();
    run_op(4'd1, 32'hFFFFFFFF, 32'd2, "mult");
    tests++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
      failed++; $display("FAIL mult_const: got %h_%h expected ffffffff_fffffffe", hi, lo);
    end
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, "multu");
    tests++;
    if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
      failed++; $display("FAIL multu_const: got %h_%h expected 00000001_fffffffe", hi, lo);
    end
  endtask

  task automatic test_div();
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, "div");
    tests++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      failed++; $display("FAIL div_const: got %h_%h expected ffffffff_fffffffd", hi, lo);
    end
    run_op(4'd4, 32'd7, 32'd2, "divu");
    tests++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      failed++; $display("FAIL divu_const: got %h_%h expected 00000001_00000003", hi, lo);
    end
  endtask

  task automatic test_move();
    run_op(4'd5, 32'h12345678, 32'h0, "mthi");
    check_reads("mthi");
    run_op(4'd6, 32'hAAAA5555, 32'h0, "mtlo");
    run_op(4'd4, 32'd99, 32'd0, "divu_by_zero");
    tests++;
    if (lo !== 32'hAAAA5555 || hi !== 32'h12345678) begin
      failed++; $display("FAIL divzero_const: got %h_%h expected 12345678_aaaa5555", hi, lo);
    end
    run_op(4'd3, 32'h80000001, 32'd0, "div_by_zero");
  endtask

  task automatic test_flush();
    int cnt;
    @(negedge clk);
    op_s = 4'd1; a_s = 32'h7; b_s = 32'h9; flush_s = 1'b1;
    #1;
    tests++;
    if (sob !== 1'b0) begin failed++; $display("FAIL flush_sob: got %b expected 0", sob); end
    @(negedge clk);
    op_s = 4'd0; flush_s = 1'b0;
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL flush_busy: got %b expected 0", busy); end
    check_regs("flush_noissue");

    // Flush pulsed during a run must not abort it.
    void'(ref_exec(4'd1, 32'h0001_0003, 32'hFFFF_FFFD));
    @(negedge clk);
    op_s = 4'd1; a_s = 32'h0001_0003; b_s = 32'hFFFF_FFFD;
    @(negedge clk);
    op_s = 4'd0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 60) begin
      cnt++;
      flush_s = (cnt == 2);
      @(negedge clk);
    end
    flush_s = 1'b0;
    tests++;
    if (cnt != MULT_N) begin failed++; $display("FAIL flush_mid_busy: got %0d expected %0d", cnt, MULT_N); end
    check_regs("flush_mid");
  endtask

  task automatic test_reset_mid();
    run_op(4'd5, 32'hDEAD0001, 32'h0, "pre_reset_hi");
    @(negedge clk);
    op_s = 4'd1; a_s = 32'h1234; b_s = 32'h5678;
    @(negedge clk);
    op_s = 4'd0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
    check_regs("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL reset_after_busy: got %b expected 0", busy); end
    check_regs("reset_after");
  endtask

  task automatic test_madd();
    run_op(4'd5, 32'h0, 32'h0, "madd_sethi");
    run_op(4'd6, 32'hFFFFFFFF, 32'h0, "madd_setlo");
    run_op(4'd10, 32'd1, 32'd1, "maddu");
`ifdef MDU_MADD_EN
    tests++;
    if (hi !== 32'd1 || lo !== 32'd0) begin
      failed++; $display("FAIL maddu_const: got %h_%h expected 00000001_00000000", hi, lo);
    end
`endif
    run_op(4'd9, 32'hFFFFFFFE, 32'd3, "madd");
    run_op(4'd11, 32'd5, 32'hFFFFFFFF, "msub");
    run_op(4'd12, 32'hFFFFFFFF, 32'h10, "msubu");
  endtask

  task automatic test_random();
    logic [3:0] ops [10];
    logic [3:0] op;
    logic [31:0] a, b;
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11, 4'd12};
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 9)];
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      run_op(op, a, b, "random");
      if (i % 5 == 0) check_reads("random_reads");
    end
  endtask

  task automatic test_back_to_back();
    run_op(4'd4, 32'd100, 32'd7, "b2b_divu");
    run_op(4'd1, 32'h80000000, 32'h80000000, "b2b_mult");
    run_op(4'd3, 32'h80000000, 32'd3, "b2b_div");
    check_reads("b2b_reads");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_flush();
    test_reset_mid();
    test_madd();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mdu_e.md
Name: mdu_e

Overview:
- Multiply/divide unit in the E stage, directly downstream of the E-stage forwarding muxes; its A/B operands are the forward-corrected rs/rt values.
- Executes mult/multu/div/divu with fixed multi-cycle latency and owns the HI/LO registers.
- Serves mthi/mtlo/mfhi/mflo.
- Exports busy/start information that the hazard unit uses to stall MDU-class instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- MDU_i_A  in  32  forwarded rs value.
- MDU_i_B  in  32  forwarded rt value.
- MDU_i_op  in  4  MDU operation of the instruction currently in E (MDU_OP_* encoding).
- MDU_i_flush  in  1  suppresses issue of this cycle's op (exception/interrupt squash).
- MDU_o_busy  out  1  an operation is in flight.
- MDU_o_startOrBusy  out  1  combinational: busy, or a mult/div-class op is present with flush low.
- MDU_o_HI  out  32  committed HI.
- MDU_o_LO  out  32  committed LO.
- MDU_o_rdata  out  32  HI for MFHI, LO for MFLO, 0 otherwise (combinational).

Behaviour:
- Reset (async, any time including mid-operation): state IDLE, counter 0, HI=LO=0, busy=0. Any pending result is discarded.
- FSM states:
  - IDLE→BUSY on a clock edge where op∈{MULT,MULTU,DIV,DIVU}, flush=0 and state=IDLE. At that edge, capture the full 64-bit result into temp registers and load the counter with MULT_CYCLES or DIV_CYCLES.
  - BUSY: counter decrements each edge. At the edge where counter==1, commit temp to HI/LO, return to IDLE, drop busy.
- Timing: op issued in cycle t → busy=1 in cycles t+1..t+N, new HI/LO visible and busy=0 in cycle t+N+1.
- Arithmetic:
  - mult/multu: 64-bit signed/unsigned product, HI=[63:32], LO=[31:0].
  - div/divu: LO=quotient truncated toward zero, HI=remainder with the dividend's sign (unsigned variants: plain).
  - B==0: full busy duration still elapses, but HI/LO are left unchanged.
- MTHI/MTLO: when IDLE and flush=0, HI (or LO) ←A at the edge ending the issue cycle. No busy.
- MFHI/MFLO: pure read of committed registers. The hazard unit guarantees they are never in E while busy.
- Simultaneous events:
  - Any MDU op in E while busy is ignored. The hazard unit must prevent this; a simulation-only assertion flags it.
  - flush=1 with a mult/div op: no issue, MDU_o_startOrBusy=0 from that op, state unchanged.
  - flush never aborts an operation already in flight; it completes and commits.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: adds MADD/MADDU/MSUB/MSUBU. Result = {HI,LO} ± A×B (signed/unsigned), MULT_CYCLES latency. {HI,LO} is sampled at issue.
- Undefined: these encodings decode as NONE (no effect, no busy).

Decomposition:
- Shared constants go in macro.v: MDU_OP_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12; FSM state encodings MDU_ST_IDLE/MDU_ST_BUSY.
- One combinational sub-module, mdu_calc: op, A, B, HI, LO → 64-bit result plus div-by-zero flag.
- mdu_e holds the FSM, counter, temp and HI/LO registers.

Test Plan:
- MULT A=0xFFFFFFFF, B=2 → busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → busy exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 → LO=3, HI=1.
- MTHI A=0x12345678 then MFHI next cycle → MDU_o_rdata=0x12345678, busy never asserted; DIVU B=0 after MTLO 0xAAAA5555 → LO stays 0xAAAA5555 after 10 busy cycles.
- MULT with flush=1 → MDU_o_startOrBusy=0, busy stays 0, HI/LO unchanged; MULT issued, then flush pulsed mid-operation → result still commits at cycle t+6.
- MULT issued, reset asserted at cycle t+3 asynchronously → busy=0 and HI=LO=0 immediately; no commit afterwards.
- (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 → HI=1, LO=0 after 5 cycles.
